axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI4 responder (slave end) for one SRAM bank; the AXI bridge's slave-side channels (AR/R/AW/W/B, 8-bit slave IDs) terminate here.
- Converts read and write bursts into single-word accesses on a synchronous SRAM macro with 1-cycle read latency.
- Instantiated once per memory slave (IM, DM) behind the bridge.

Parameters:
- SRAM_AW, 14, SRAM word-address width; word index = ADDR[SRAM_AW+1:2], wraps modulo 2^SRAM_AW.
- RESP_OKAY, 2'b00, response for a legal transfer.
- RESP_SLVERR, 2'b10, response for an unsupported size/burst or WLAST mismatch.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ARID_S  in  8  read ID. ARADDR  in  32. ARLEN  in  4. ARSIZE  in  3. ARBURST  in  2. ARVALID  in  1.
- ARREADY  out  1.
- RID_S  out  8. RDATA  out  32. RRESP  out  2. RLAST  out  1. RVALID  out  1.
- RREADY  in  1.
- AWID_S  in  8. AWADDR  in  32. AWLEN  in  4. AWSIZE  in  3. AWBURST  in  2. AWVALID  in  1.
- AWREADY  out  1.
- WDATA  in  32. WSTRB  in  4. WLAST  in  1. WVALID  in  1.
- WREADY  out  1.
- BID_S  out  8. BRESP  out  2. BVALID  out  1.
- BREADY  in  1.
- SRAM_CS  out  1  chip select. SRAM_OE  out  1  read enable. SRAM_WEB  out  4  active-low byte write enables.
- SRAM_A  out  SRAM_AW  word address. SRAM_DI  out  32  write data.
- SRAM_DO  in  32  read data, valid 1 cycle after a read address is presented.

Behaviour:
- Reset (async, rst=1) state: FSM=IDLE. All ready/valid outputs 0. RDATA, RID_S, BID_S, RRESP, BRESP, RLAST 0. SRAM_CS=0, SRAM_OE=0, SRAM_WEB=4'hF, SRAM_A=0, SRAM_DI=0.
- Reset mid-burst abandons the burst; no further SRAM write occurs after reset asserts.
- FSM states: IDLE, R_FETCH, R_DATA, W_DATA, W_RESP.
- IDLE:
  - ARREADY=1. AWREADY = !ARVALID (read has priority when both are valid in the same cycle).
  - AR handshake: latch ID, address, len, burst; err = (ARSIZE!=3'b010) or (ARBURST==2'b11); -> R_FETCH.
  - AW handshake (only when no AR handshake): latch ID, address, len, burst; err computed the same way; beat counter=0; -> W_DATA.
- R_FETCH (1 cycle): SRAM_CS=1, SRAM_OE=1, SRAM_A=word index; -> R_DATA.
- R_DATA:
  - SRAM_DO is captured into an RDATA register on entry, so RDATA stays stable while RVALID=1 and RREADY=0.
  - RVALID=1; RID_S=latched ID; RLAST = (beat==len); RRESP = err ? SLVERR : OKAY.
  - On RREADY: if RLAST -> IDLE; else beat+1, address update, -> R_FETCH.
  - Latency: AR handshake at cycle t -> first RVALID at t+2. Throughput: one beat per 2 cycles.
- Address update:
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01) and WRAP (2'b10): address += 4 (WRAP is executed as INCR but is legal).
  - Word index wraps at 2^SRAM_AW.
- W_DATA:
  - WREADY=1.
  - On WVALID: if beat<=len and !err, then SRAM_CS=1, SRAM_WEB=~WSTRB, SRAM_DI=WDATA, SRAM_A=word index in the same cycle. Otherwise no write, and err is set if beat>len.
  - Then beat+1 and address update.
  - If WLAST=1 and beat!=len, err is set.
  - WLAST handshake -> W_RESP.
  - Burst termination is governed by WLAST only.
- W_RESP: BVALID=1, BID_S=latched ID, BRESP = err ? SLVERR : OKAY; held until BREADY -> IDLE.
- SRAM outputs outside the active cycles: CS=0, OE=0, WEB=4'hF.
- ARLEN/AWLEN=0 is a single beat; the maximum is 16 beats.

Decomposition:
- Existing AXI define file supplies ID/IDS/ADDR/LEN/SIZE/DATA/STRB widths.
- New package axi_pkg holds:
  - state enum;
  - BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR constants;
  - SIZE_WORD=3'b010;
  - next-address function.
- One sub-module: axi_sram_addr_gen, which holds the latched address/len/burst, beat counter, last flag and next-address logic.

Test Plan:
- Single read: SRAM word 5 = 32'hDEADBEEF; AR addr=0x14, len=0, id=8'h12 -> RVALID at t+2 with RDATA=DEADBEEF, RLAST=1, RID_S=12, RRESP=00.
- INCR read burst: addr=0x0, len=3, RREADY low for 3 cycles on beat 1 -> data words 0..3 in order; RDATA stable while stalled; RLAST only on beat 3.
- Byte-strobe write: word 2 = 32'h11223344; AW addr=0x8 len=0, WDATA=32'hAABBCCDD, WSTRB=4'b0101 -> SRAM_WEB=4'b1010; word reads back 32'h11BB33DD; BRESP=00 after BREADY.
- Simultaneous ARVALID and AWVALID in IDLE -> ARREADY=1, AWREADY=0; read completes; write is accepted the cycle after return to IDLE.
- Error cases: ARSIZE=3'b001 -> RRESP=10. Write with AWLEN=1 but WLAST on beat 0 -> BRESP=10; beat 0 is still written.
- Async reset asserted mid write burst -> all outputs at reset values immediately; no SRAM write afterwards; a new AW is accepted after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI widths, FSM state type, burst/response encodings and address helpers
// for the SRAM responder.
package axi_pkg;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {StIdle, StRFetch, StRData, StWData, StWResp} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // WRAP is carried out as INCR; only the reserved encoding is rejected.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst > BURST_WRAP);
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] word, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? word : word + 32'd1;
  endfunction

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Burst bookkeeping: latched word index, length and burst type, beat counter,
// and last/overrun flags for the current burst.
module axi_sram_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SRAM_AW-1:0] idx_in,
  input  logic [3:0]         len_in,
  input  logic [1:0]         burst_in,
  input  logic               advance,
  output logic [SRAM_AW-1:0] word_idx,
  output logic               last,
  output logic               over
);

  logic [SRAM_AW-1:0] idx_q;
  logic [3:0]         len_q;
  logic [1:0]         burst_q;
  logic [4:0]         beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else if (load) begin
      idx_q   <= idx_in;
      len_q   <= len_in;
      burst_q <= burst_in;
      beat_q  <= '0;
    end else if (advance) begin
      idx_q <= SRAM_AW'(next_word(32'(idx_q), burst_q));
      // Saturate so a missing WLAST can never wrap back into a writable beat.
      if (beat_q != 5'd16) beat_q <= beat_q + 5'd1;
    end
  end

  assign word_idx = idx_q;
  assign last     = (beat_q == {1'b0, len_q});
  assign over     = (beat_q > {1'b0, len_q});

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one SRAM bank: bursts become single-word SRAM accesses,
// one beat every two cycles on reads.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ARID_S,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [7:0]         RID_S,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  input  logic [7:0]         AWID_S,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [7:0]         BID_S,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  output logic               SRAM_CS,
  output logic               SRAM_OE,
  output logic [3:0]         SRAM_WEB,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic [31:0]        SRAM_DI,
  input  logic [31:0]        SRAM_DO
);

  state_e             state_q, state_d;
  logic [7:0]         id_q, id_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q;
  logic               fresh_q;
  logic               ar_hs, aw_hs, advance, last, over;
  logic [SRAM_AW-1:0] word_idx;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{ARADDR[31:SRAM_AW+2], ARADDR[1:0],
                              AWADDR[31:SRAM_AW+2], AWADDR[1:0]};

  assign ar_hs = (state_q == StIdle) && ARVALID;
  assign aw_hs = (state_q == StIdle) && !ARVALID && AWVALID;

  axi_sram_addr_gen #(
    .SRAM_AW (SRAM_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ar_hs || aw_hs),
    .idx_in   (ar_hs ? ARADDR[SRAM_AW+1:2] : AWADDR[SRAM_AW+1:2]),
    .len_in   (ar_hs ? ARLEN : AWLEN),
    .burst_in (ar_hs ? ARBURST : AWBURST),
    .advance  (advance),
    .word_idx (word_idx),
    .last     (last),
    .over     (over)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    err_d    = err_q;
    advance  = 1'b0;
    ARREADY  = 1'b0;
    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    RVALID   = 1'b0;
    BVALID   = 1'b0;
    SRAM_CS  = 1'b0;
    SRAM_OE  = 1'b0;
    SRAM_WEB = 4'hF;
    SRAM_A   = '0;
    SRAM_DI  = '0;
    unique case (state_q)
      StIdle: begin
        ARREADY = 1'b1;
        AWREADY = !ARVALID;
        if (ar_hs) begin
          id_d    = ARID_S;
          err_d   = req_err(ARSIZE, ARBURST);
          state_d = StRFetch;
        end else if (aw_hs) begin
          id_d    = AWID_S;
          err_d   = req_err(AWSIZE, AWBURST);
          state_d = StWData;
        end
      end
      StRFetch: begin
        SRAM_CS = 1'b1;
        SRAM_OE = 1'b1;
        SRAM_A  = word_idx;
        state_d = StRData;
      end
      StRData: begin
        RVALID = 1'b1;
        if (RREADY) begin
          if (last) begin
            state_d = StIdle;
          end else begin
            advance = 1'b1;
            state_d = StRFetch;
          end
        end
      end
      StWData: begin
        WREADY = 1'b1;
        if (WVALID) begin
          if (!over && !err_q) begin
            SRAM_CS  = 1'b1;
            SRAM_WEB = ~WSTRB;
            SRAM_DI  = WDATA;
            SRAM_A   = word_idx;
          end
          advance = 1'b1;
          if (over || (WLAST && !last)) err_d = 1'b1;
          if (WLAST) state_d = StWResp;
        end
      end
      StWResp: begin
        BVALID = 1'b1;
        if (BREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Keep the address channels closed for as long as reset is held.
    if (rst) begin
      ARREADY = 1'b0;
      AWREADY = 1'b0;
    end
  end

  assign RID_S = (state_q == StRData) ? id_q : 8'h00;
  assign RRESP = ((state_q == StRData) && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST = (state_q == StRData) && last;
  assign BID_S = (state_q == StWResp) ? id_q : 8'h00;
  assign BRESP = ((state_q == StWResp) && err_q) ? RESP_SLVERR : RESP_OKAY;
  // SRAM_DO is only valid in the first R_DATA cycle; afterwards the held copy is shown.
  assign RDATA = fresh_q ? SRAM_DO : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
      fresh_q <= (state_q == StRFetch);
      if (fresh_q) rdata_q <= SRAM_DO;
    end
  end

endmodule
